// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder and the register bank:
// opcodes, decoder FSM states and STATUS byte layout.
package spi_cmd_pkg;

    localparam logic [7:0] OP_REG_WRITE = 8'h01;
    localparam logic [7:0] OP_REG_READ  = 8'h02;
    localparam logic [7:0] OP_FB_WRITE  = 8'h03;
    localparam logic [7:0] OP_STATUS    = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } state_t;

    localparam int STAT_FB_BUSY = 0;
    localparam int STAT_OVERRUN = 1;

    function automatic logic [7:0] status_byte(input logic overrun, input logic fb_busy);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_OVERRUN] = overrun;
        s[STAT_FB_BUSY] = fb_busy;
        return s;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Framebuffer write port: address/data held with fb_we until fb_ready accepts.
interface spi_cmd_decoder_if #(
    parameter int FB_ADDR_W = 17
);
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [7:0]           fb_wdata;
    logic                 fb_we;
    logic                 fb_ready;

    modport master (output fb_addr, fb_wdata, fb_we, input fb_ready);
    modport slave  (input fb_addr, fb_wdata, fb_we, output fb_ready);
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: frames opcode/address/data bytes into register and framebuffer writes.
// Define SPI_CMD_READ_EN to enable REG_READ/STATUS decoding and tx_byte readback.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int FB_ADDR_W = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       msg_start,
    input  logic       msg_end,
    output logic [7:0] tx_byte,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    spi_cmd_decoder_if.master fb
);

    state_t               state, state_next;
    logic [7:0]           op_q;
    logic [1:0]           addr_cnt;
    logic [FB_ADDR_W-1:0] fb_addr_q;
    logic [7:0]           fb_wdata_q;
    logic                 fb_we_q;
    logic                 overrun;

    logic byte_ok, opcode_byte, addr_byte, data_byte;
    logic fb_accept, fb_slot_free;

    function automatic state_t decode_opcode(input logic [7:0] op);
        case (op)
            OP_REG_WRITE, OP_FB_WRITE: return ST_ADDR;
`ifdef SPI_CMD_READ_EN
            OP_REG_READ:               return ST_ADDR;
            OP_STATUS:                 return ST_DATA;
`endif
            default:                   return ST_IGNORE;
        endcase
    endfunction

    // A byte arriving together with msg_start belongs to no message and is dropped.
    assign byte_ok     = rx_valid && !msg_start;
    assign opcode_byte = byte_ok && (state == ST_OPCODE);
    assign addr_byte   = byte_ok && (state == ST_ADDR);
    assign data_byte   = byte_ok && (state == ST_DATA);

    assign fb_accept    = fb_we_q && fb.fb_ready;
    assign fb_slot_free = !fb_we_q || fb.fb_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (msg_start)
            state_next = ST_OPCODE;
        else if (msg_end)
            state_next = ST_IDLE;
        else if (opcode_byte)
            state_next = decode_opcode(rx_byte);
        else if (addr_byte && (op_q != OP_FB_WRITE || addr_cnt == 2'd2))
            state_next = ST_DATA;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= 8'h00;
            addr_cnt   <= 2'd0;
            reg_addr   <= 8'h00;
            reg_wdata  <= 8'h00;
            reg_we     <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= 8'h00;
            fb_we_q    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            if (msg_start)   addr_cnt <= 2'd0;
            if (opcode_byte) op_q <= rx_byte;

            // Register address post-increments once the write strobe has been seen.
            if (reg_we) reg_addr <= reg_addr + 8'd1;

            if (addr_byte) begin
                addr_cnt <= addr_cnt + 2'd1;
                if (op_q != OP_FB_WRITE) reg_addr <= rx_byte;
            end

            if (data_byte && op_q == OP_REG_WRITE) begin
                reg_we    <= 1'b1;
                reg_wdata <= rx_byte;
            end

            // Address bytes arrive MSB first; only the low FB_ADDR_W bits survive.
            if (addr_byte && op_q == OP_FB_WRITE) begin
                if (addr_cnt == 2'd0) fb_addr_q <= FB_ADDR_W'(rx_byte);
                else                  fb_addr_q <= FB_ADDR_W'({fb_addr_q, rx_byte});
            end else if (fb_accept) begin
                fb_addr_q <= fb_addr_q + FB_ADDR_W'(1);
            end

            if (data_byte && op_q == OP_FB_WRITE) begin
                if (fb_slot_free) begin
                    fb_we_q    <= 1'b1;
                    fb_wdata_q <= rx_byte;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (fb_accept) begin
                fb_we_q <= 1'b0;
            end

`ifdef SPI_CMD_READ_EN
            if (data_byte && op_q == OP_REG_READ) reg_addr <= reg_addr + 8'd1;
            if (msg_end && !msg_start && state == ST_DATA && op_q == OP_STATUS)
                overrun <= 1'b0;
`endif
        end
    end

`ifdef SPI_CMD_READ_EN
    logic [7:0] tx_q;
    logic       rd_load;

    // Readback: address update on the byte strobe, registered read one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q    <= 8'h00;
            rd_load <= 1'b0;
        end else begin
            rd_load <= (addr_byte || data_byte) && (op_q == OP_REG_READ);
            if (state == ST_DATA && op_q == OP_STATUS)
                tx_q <= status_byte(overrun, fb_we_q);
            else if (state == ST_DATA && op_q == OP_REG_READ) begin
                if (rd_load) tx_q <= reg_rdata;
            end else
                tx_q <= 8'h00;
        end
    end

    assign tx_byte = tx_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^reg_rdata;
    assign tx_byte      = 8'h00;
`endif

    assign fb.fb_addr  = fb_addr_q;
    assign fb.fb_wdata = fb_wdata_q;
    assign fb.fb_we    = fb_we_q;

endmodule
